// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: imem req/gnt/rvalid bus, EX redirect, ID valid/ready.
// master = fetch unit, slave = memory / EX / ID side.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  redirect,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output redirect,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: PC, in-order imem fetch, instruction buffer, redirect flush.
// Define IF_BYPASS_EN to forward a response straight to ID when the buffer is empty.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic             clk,
  input logic             rst_n,
  if_fetch_unit_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QW  =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]  pc_q;
  logic [OW-1:0] out_q;
  logic [OW-1:0] out_d;
  logic [OW-1:0] disc_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [31:0]  hold_q;
  logic [31:0]  occ;

  fetch_entry_t fifo_q [FIFO_DEPTH];
  logic [31:0]  rq_q [MAX_OUTSTANDING];

  fetch_entry_t head;
  fetch_entry_t rsp_e;
  logic [QW-1:0] rq_wr;

  logic fire;
  logic rsp;
  logic keep;
  logic empty;
  logic byp;
  logic push;
  logic pop;

  assign occ   = 32'(cnt_q) + 32'(out_q);
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_q];

  // Space is reserved at issue time, so a push never finds the buffer full.
  assign bus.imem_req = rst_n
                      & (occ < FIFO_DEPTH)
                      & (32'(out_q) < MAX_OUTSTANDING)
                      & ~bus.redirect;
  assign bus.imem_addr = pc_q;

  assign fire  = bus.imem_req & bus.imem_gnt;
  assign rsp   = bus.imem_rvalid & (out_q != '0);
  assign keep  = rsp & (disc_q == '0) & ~bus.redirect;
  assign out_d = out_q + OW'(fire) - OW'(rsp);
  assign rsp_e = '{instr: bus.imem_rdata, pc: rq_q[0]};
  assign rq_wr = QW'(out_q - OW'(rsp));

`ifdef IF_BYPASS_EN
  assign byp = empty & keep;
`else
  assign byp = 1'b0;
`endif

  assign pop  = ~empty & bus.id_ready & ~bus.redirect;
  assign push = keep & ~(byp & bus.id_ready);

  always_comb begin
    bus.id_valid = 1'b0;
    bus.id_instr = NOP;
    bus.id_pc    = hold_q;
    unique case (1'b1)
      !empty: begin
        bus.id_valid = 1'b1;
        bus.id_instr = head.instr;
        bus.id_pc    = head.pc;
      end
      byp: begin
        bus.id_valid = 1'b1;
        bus.id_instr = rsp_e.instr;
        bus.id_pc    = rsp_e.pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      disc_q <= '0;
      hold_q <= '0;
    end else begin
      out_q  <= out_d;
      hold_q <= bus.id_pc;
      if (bus.redirect) begin
        pc_q   <= bus.redirect_pc & 32'hFFFF_FFFC;
        disc_q <= out_d;
      end else begin
        if (fire) pc_q <= pc_q + 32'd4;
        if (rsp && disc_q != '0) disc_q <= disc_q - OW'(1);
      end
    end
  end

  // PCs of requests in flight, oldest at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) rq_q[i] <= '0;
    end else begin
      if (rsp) begin
        for (int i = 0; i < int'(MAX_OUTSTANDING) - 1; i++) begin
          rq_q[i] <= rq_q[i+1];
        end
      end
      if (fire) rq_q[rq_wr] <= pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (bus.redirect) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_q] <= rsp_e;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && 32'(cnt_q) == FIFO_DEPTH));

  a_out_bound: assert property (@(posedge clk) disable iff (!rst_n)
    32'(out_q) <= MAX_OUTSTANDING);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: queue-level model compared every cycle,
// plus literal expectations on the fetch and delivery streams.
module tb_if_fetch_unit;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic        stale;
  } fly_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_fetch_unit_if bus();

  if_fetch_unit #(
    .RESET_PC(RPC),
    .FIFO_DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic rsp_en = 1'b0;
  logic force_rv = 1'b0;

  fly_t fly_q[$];
  ent_t buf_q[$];
  logic [31:0] mpc = RPC;
  logic [31:0] last_pc = '0;

  logic [31:0] mem_q[$];
  logic nxt_rv = 1'b0;
  logic nxt_real = 1'b0;
  logic cur_real = 1'b0;
  logic [31:0] nxt_rd = '0;

  logic [31:0] fetched[$];
  ent_t delivered[$];
  int cyc = 0;
  int first_gnt = -1;
  int first_val = -1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] dpc(input int i);
    if (i < delivered.size()) return delivered[i].pc;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dins(input int i);
    if (i < delivered.size()) return delivered[i].instr;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] fadr(input int i);
    if (i < fetched.size()) return fetched[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory response driver: one cycle after grant at the earliest.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_rvalid = nxt_rv;
      bus.imem_rdata  = nxt_rd;
      cur_real        = nxt_real;
    end
  end

  always @(negedge clk) begin : model_p
    logic e_req, e_val, fire, rsp, byp;
    logic [31:0] e_ins, e_pc;
    fly_t f;
    if (!rst_n) begin
      chk("rst_imem_req", 32'(bus.imem_req), 0);
      chk("rst_imem_addr", bus.imem_addr, RPC);
      chk("rst_id_valid", 32'(bus.id_valid), 0);
      chk("rst_id_instr", bus.id_instr, NOP);
      chk("rst_id_pc", bus.id_pc, 0);
      fly_q.delete();
      buf_q.delete();
      mem_q.delete();
      fetched.delete();
      delivered.delete();
      mpc = RPC;
      last_pc = '0;
      nxt_rv = 1'b0;
      nxt_real = 1'b0;
      nxt_rd = '0;
      cyc = 0;
      first_gnt = -1;
      first_val = -1;
    end else begin
      cyc++;
      rsp   = bus.imem_rvalid && fly_q.size() > 0;
      e_req = (buf_q.size() + fly_q.size() < DEPTH)
              && (fly_q.size() < MAXO) && !bus.redirect;
      byp = 1'b0;
`ifdef IF_BYPASS_EN
      byp = buf_q.size() == 0 && rsp && !fly_q[0].stale && !bus.redirect;
`endif
      e_val = buf_q.size() > 0 || byp;
      e_ins = NOP;
      e_pc  = last_pc;
      if (buf_q.size() > 0) begin
        e_ins = buf_q[0].instr;
        e_pc  = buf_q[0].pc;
      end else if (byp) begin
        e_ins = instr_of(fly_q[0].pc);
        e_pc  = fly_q[0].pc;
      end

      chk("imem_req", 32'(bus.imem_req), 32'(e_req));
      chk("imem_addr", bus.imem_addr, mpc);
      chk("id_valid", 32'(bus.id_valid), 32'(e_val));
      chk("id_instr", bus.id_instr, e_ins);
      chk("id_pc", bus.id_pc, e_pc);

      if (bus.imem_req && bus.imem_gnt) begin
        fetched.push_back(bus.imem_addr);
        if (first_gnt < 0) first_gnt = cyc;
      end
      if (bus.id_valid && first_val < 0) first_val = cyc;
      if (bus.id_valid && bus.id_ready && !bus.redirect)
        delivered.push_back('{bus.id_pc, bus.id_instr});

      fire = e_req && bus.imem_gnt;
      if (bus.redirect) begin
        if (rsp) void'(fly_q.pop_front());
        foreach (fly_q[i]) fly_q[i].stale = 1'b1;
        buf_q.delete();
        mpc = bus.redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (bus.id_ready && buf_q.size() > 0) void'(buf_q.pop_front());
        if (rsp) begin
          f = fly_q.pop_front();
          if (!f.stale && !(byp && bus.id_ready))
            buf_q.push_back('{f.pc, instr_of(f.pc)});
        end
        if (fire) begin
          fly_q.push_back('{mpc, 1'b0});
          mpc = mpc + 32'd4;
        end
      end
      last_pc = e_pc;

      if (bus.imem_rvalid && cur_real && mem_q.size() > 0)
        void'(mem_q.pop_front());
      if (bus.imem_req && bus.imem_gnt) mem_q.push_back(bus.imem_addr);
      nxt_rv = 1'b0;
      nxt_real = 1'b0;
      nxt_rd = '0;
      if (rsp_en && mem_q.size() > 0) begin
        nxt_rv = 1'b1;
        nxt_real = 1'b1;
        nxt_rd = instr_of(mem_q[0]);
      end else if (force_rv) begin
        nxt_rv = 1'b1;
        nxt_rd = 32'hBAD0_BAD0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic g, input logic r, input logic y);
    rst_n = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_gnt = g;
    bus.id_ready = y;
    rsp_en = r;
    force_rv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  localparam logic [47:0] GNT_PAT = 48'hF7BD_EF3F_DEFB;
  localparam logic [47:0] RDY_PAT = 48'hCF3C_F0FF_3C9F;
  localparam logic [47:0] RSP_PAT = 48'hFDF7_BEFF_77DF;

  initial begin : main_p
    int fi, di;
    logic [47:0] gp, rp, yp;
    bus.imem_gnt = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b0;

    // Streaming at one instruction per cycle
    do_reset(1'b1, 1'b1, 1'b1);
    step(10);
    chk("s1_fetch0", fadr(0), 32'h0);
    chk("s1_fetch1", fadr(1), 32'h4);
    chk("s1_fetch2", fadr(2), 32'h8);
    chk("s1_del0_pc", dpc(0), 32'h0);
    chk("s1_del0_ins", dins(0), 32'hC0DE_0000);
    chk("s1_del1_pc", dpc(1), 32'h4);
    chk("s1_del1_ins", dins(1), 32'hC0DE_0004);
`ifdef IF_BYPASS_EN
    chk("s1_latency", first_val - first_gnt, 1);
    chk("s1_count", delivered.size(), 9);
`else
    chk("s1_latency", first_val - first_gnt, 2);
    chk("s1_count", delivered.size(), 8);
`endif

    // Stall fills the buffer, then drains back-to-back
    do_reset(1'b1, 1'b1, 1'b0);
    step(10);
    chk("s2_req_low", 32'(bus.imem_req), 0);
    chk("s2_hold_pc", bus.id_pc, 32'h0);
    chk("s2_buffered", fetched.size(), 4);
    bus.id_ready = 1'b1;
    step(6);
    chk("s2_del0", dpc(0), 32'h0);
    chk("s2_del1", dpc(1), 32'h4);
    chk("s2_del2", dpc(2), 32'h8);
    chk("s2_del3", dpc(3), 32'hC);
    chk("s2_del4", dpc(4), 32'h10);
    chk("s2_fetch4", fadr(4), 32'h10);

    // Redirect with two requests outstanding
    do_reset(1'b1, 1'b0, 1'b1);
    step(3);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    rsp_en = 1'b1;
    step(1);
    bus.redirect = 1'b0;
    step(8);
    chk("s3_fetch", fadr(2), 32'h100);
    chk("s3_del0_pc", dpc(0), 32'h100);
    chk("s3_del0_ins", dins(0), 32'hC0DE_0100);

    // Redirect in the same cycle as gnt and rvalid, unaligned target
    do_reset(1'b1, 1'b0, 1'b1);
    step(2);
    rsp_en = 1'b1;
    step(1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0202;
    step(1);
    bus.redirect = 1'b0;
    step(6);
    chk("s4_fetch", fadr(2), 32'h200);
    chk("s4_del0_pc", dpc(0), 32'h200);
    chk("s4_del0_ins", dins(0), 32'hC0DE_0200);

    // Redirect with a non-empty buffer, into the PC wrap
    do_reset(1'b1, 1'b1, 1'b1);
    step(5);
    chk("s5_pre_valid", 32'(bus.id_valid), 1);
    fi = fetched.size();
    di = delivered.size();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    step(1);
    bus.redirect = 1'b0;
    step(10);
    chk("s5_fetch0", fadr(fi), 32'hFFFF_FFF8);
    chk("s5_fetch1", fadr(fi + 1), 32'hFFFF_FFFC);
    chk("s5_fetch2", fadr(fi + 2), 32'h0000_0000);
    chk("s5_del0_pc", dpc(di), 32'hFFFF_FFF8);
    chk("s5_del0_ins", dins(di), 32'h3F21_FFF8);
    chk("s5_del1_pc", dpc(di + 1), 32'hFFFF_FFFC);
    chk("s5_del2_pc", dpc(di + 2), 32'h0000_0000);
    chk("s5_del2_ins", dins(di + 2), 32'hC0DE_0000);

    // Spurious rvalid with nothing outstanding is ignored
    do_reset(1'b0, 1'b0, 1'b1);
    force_rv = 1'b1;
    step(3);
    chk("s6_no_valid", 32'(bus.id_valid), 0);
    force_rv = 1'b0;
    bus.imem_gnt = 1'b1;
    rsp_en = 1'b1;
    step(5);
    chk("s6_del0_pc", dpc(0), 32'h0);
    chk("s6_del0_ins", dins(0), 32'hC0DE_0000);

    // Mixed grant / response / ready pattern with two redirects
    do_reset(1'b1, 1'b1, 1'b1);
    gp = GNT_PAT;
    rp = RSP_PAT;
    yp = RDY_PAT;
    for (int i = 0; i < 48; i++) begin
      bus.imem_gnt = gp[i];
      rsp_en = rp[i];
      bus.id_ready = yp[i];
      bus.redirect = (i == 20) || (i == 33);
      bus.redirect_pc = (i == 20) ? 32'h0000_0404 : 32'h0000_0803;
      step(1);
    end
    bus.redirect = 1'b0;
    bus.id_ready = 1'b1;
    rsp_en = 1'b1;
    step(8);

    // Asynchronous reset with three entries buffered
    do_reset(1'b1, 1'b1, 1'b0);
    step(4);
    chk("s8_pre_valid", 32'(bus.id_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s8_valid", 32'(bus.id_valid), 0);
    chk("s8_instr", bus.id_instr, NOP);
    chk("s8_req", 32'(bus.imem_req), 0);
    chk("s8_pc", bus.id_pc, 32'h0);
    @(posedge clk);
    #1;
    bus.id_ready = 1'b1;
    rst_n = 1'b1;
    step(3);
    chk("s8_fetch0", fadr(0), RPC);
    chk("s8_nfetch", fetched.size(), 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
